// File: rtl/de1_soc_hex_pkg.sv
// Shared types and constants for the DE1-SoC HEX display controller:
// FSM state encoding, the active-low 7-segment lookup table and the
// helpers that pack segment codes into HEX PIO data words.
package de1_soc_hex_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2
    } hex_state_t;

    // Bit 6..0 = segment g..a, a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // HEX3_0 PIO word: one byte per digit, bit 7 of each byte unused.
    function automatic logic [31:0] pack_lo_word(input logic [6:0] seg0,
                                                 input logic [6:0] seg1,
                                                 input logic [6:0] seg2,
                                                 input logic [6:0] seg3);
        return {1'b0, seg3, 1'b0, seg2, 1'b0, seg1, 1'b0, seg0};
    endfunction

    // HEX5_4 PIO word: only the low two bytes carry digits.
    function automatic logic [31:0] pack_hi_word(input logic [6:0] seg4,
                                                 input logic [6:0] seg5);
        return {16'h0000, 1'b0, seg5, 1'b0, seg4};
    endfunction

endpackage

// File: rtl/de1_soc_hex_7seg_enc.sv
// Combinational nibble to active-low 7-segment encoder with a blank override.
module de1_soc_hex_7seg_enc
    import de1_soc_hex_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : SEG_LUT[nibble];

endmodule

// File: rtl/de1_soc_hex_display_ctrl.sv
// Avalon-MM master that keeps the HEX3_0 / HEX5_4 PIOs in sync with a 24-bit
// value: a write pair on every value update and on every refresh tick.
// Optional build macro: DE1_SOC_HEX_LZB_EN enables leading-zero blanking.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no write pending on the bus; waits for an update or a tick
// ST_WR_LO  | writing the HEX3_0 word, held until waitrequest drops
// ST_WR_HI  | writing the HEX5_4 word, held until waitrequest drops
module de1_soc_hex_display_ctrl
    import de1_soc_hex_pkg::*;
#(
    parameter int unsigned              ADDR_W         = 32,
    parameter logic [ADDR_W-1:0]        HEX3_0_ADDR    = 'h0000_0020,
    parameter logic [ADDR_W-1:0]        HEX5_4_ADDR    = 'h0000_0030,
    parameter int unsigned              REFRESH_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [23:0]       value,
    input  logic              value_valid,
    output logic              busy,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest
);

    localparam int unsigned CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((REFRESH_CYCLES == 0) ? 0 : REFRESH_CYCLES - 1);

    hex_state_t        state_q, state_d;
    logic [23:0]       cur_value_q;
    logic              pending_q, pending_d;
    logic [CNT_W-1:0]  refresh_cnt_q;
    logic              refresh_tick;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       hi_word_q, hi_word_d;

    // A strobe in the same cycle as the pair launch must be displayed at once,
    // so the encoders look at the incoming value rather than the stored one.
    logic [23:0] snap_value;
    logic [5:0]  blank;
    logic [6:0]  seg [6];

    assign snap_value = value_valid ? value : cur_value_q;

`ifdef DE1_SOC_HEX_LZB_EN
    // A digit is blanked when it and every digit above it are zero; HEX0 never blanks.
    assign blank[0] = 1'b0;
    for (genvar g = 1; g < 6; g++) begin : g_lzb
        assign blank[g] = ~|snap_value[23:4*g];
    end
`else
    assign blank = '0;
`endif

    for (genvar g = 0; g < 6; g++) begin : g_enc
        de1_soc_hex_7seg_enc u_enc (
            .nibble (snap_value[4*g +: 4]),
            .blank  (blank[g]),
            .seg    (seg[g])
        );
    end

    assign refresh_tick = (REFRESH_CYCLES != 0) && (refresh_cnt_q == CNT_LAST);

    // Free-running refresh timer, wraps on its terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt_q <= '0;
        end else if (REFRESH_CYCLES != 0) begin
            refresh_cnt_q <= refresh_tick ? '0 : refresh_cnt_q + 1'b1;
        end
    end

    // Latest value wins; captured in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_value_q <= '0;
        end else if (value_valid) begin
            cur_value_q <= value;
        end
    end

    // Next-state and registered-output decode; ticks outside IDLE are dropped.
    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        data_d    = data_q;
        hi_word_d = hi_word_q;
        pending_d = pending_q | value_valid;
        case (state_q)
            ST_IDLE: begin
                if (pending_q || value_valid || refresh_tick) begin
                    state_d   = ST_WR_LO;
                    write_d   = 1'b1;
                    addr_d    = HEX3_0_ADDR;
                    data_d    = pack_lo_word(seg[0], seg[1], seg[2], seg[3]);
                    hi_word_d = pack_hi_word(seg[4], seg[5]);
                    pending_d = 1'b0;
                end
            end
            ST_WR_LO: begin
                if (!avm_waitrequest) begin
                    state_d = ST_WR_HI;
                    addr_d  = HEX5_4_ADDR;
                    data_d  = hi_word_q;
                end
            end
            ST_WR_HI: begin
                if (!avm_waitrequest) begin
                    state_d = ST_IDLE;
                    write_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                write_d = 1'b0;
            end
        endcase
    end

    // State and bus-output registers; reset abandons any pair in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            hi_word_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            hi_word_q <= hi_word_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign avm_write      = write_q;
    assign avm_address    = addr_q;
    assign avm_writedata  = data_q;
    assign avm_byteenable = 4'hF;

endmodule

// File: tb/tb_de1_soc_hex_display_ctrl.sv
// Self-checking bench for de1_soc_hex_display_ctrl with a transaction-level
// reference model and randomized traffic.
module tb_de1_soc_hex_display_ctrl;

    localparam int unsigned R = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] value;
    logic        value_valid;
    logic        busy;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    de1_soc_hex_display_ctrl #(
        .ADDR_W         (32),
        .HEX3_0_ADDR    (32'h0000_0020),
        .HEX5_4_ADDR    (32'h0000_0030),
        .REFRESH_CYCLES (R)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .value           (value),
        .value_valid     (value_valid),
        .busy            (busy),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [3:0] nib(input logic [23:0] v, input int k);
        logic [23:0] t;
        t = v >> (4 * k);
        return t[3:0];
    endfunction

    function automatic logic [6:0] digit_seg(input logic [23:0] v, input int k);
`ifdef DE1_SOC_HEX_LZB_EN
        int top;
        top = 0;
        for (int i = 0; i < 6; i++)
            if (nib(v, i) != 4'h0) top = i;
        if (k > top) return 7'h7F;
`endif
        return seg_of(nib(v, k));
    endfunction

    function automatic logic [31:0] exp_lo(input logic [23:0] v);
        return (32'(digit_seg(v, 3)) << 24) | (32'(digit_seg(v, 2)) << 16) |
               (32'(digit_seg(v, 1)) << 8)  |  32'(digit_seg(v, 0));
    endfunction

    function automatic logic [31:0] exp_hi(input logic [23:0] v);
        return (32'(digit_seg(v, 5)) << 8) | 32'(digit_seg(v, 4));
    endfunction

    // Reference model: phase 0 = no pair, 1 = LO word on bus, 2 = HI word on bus.
    int          m_phase = 0;
    int unsigned m_cnt   = 0;
    bit          m_pend  = 1'b0;
    logic [23:0] m_cur   = '0;
    logic [23:0] m_shown = '0;

    always @(posedge clk) begin
        bit          tick;
        logic [23:0] latest;
        if (reset) begin
            m_phase = 0;
            m_cnt   = 0;
            m_pend  = 1'b0;
            m_cur   = '0;
        end else begin
            tick   = (m_cnt == R - 1);
            m_cnt  = tick ? 0 : m_cnt + 1;
            latest = value_valid ? value : m_cur;
            if (m_phase == 0) begin
                if (m_pend || value_valid || tick) begin
                    m_phase = 1;
                    m_shown = latest;
                    m_pend  = 1'b0;
                end
            end else begin
                if (value_valid) m_pend = 1'b1;
                if (!avm_waitrequest) m_phase = (m_phase == 1) ? 2 : 0;
            end
            m_cur = latest;
        end
    end

    task automatic compare_all();
        chk("write", 32'(avm_write), 32'(m_phase != 0));
        chk("busy",  32'(busy),      32'(m_phase != 0));
        chk("byteenable", 32'(avm_byteenable), 32'h0000_000F);
        if (m_phase == 1) begin
            chk("lo_addr", avm_address,   32'h0000_0020);
            chk("lo_data", avm_writedata, exp_lo(m_shown));
        end else if (m_phase == 2) begin
            chk("hi_addr", avm_address,   32'h0000_0030);
            chk("hi_data", avm_writedata, exp_hi(m_shown));
        end
    endtask

    int rises;
    logic prev_write;

    task automatic cyc(input logic rst, input logic vv, input logic [23:0] v, input logic wr);
        reset           = rst;
        value_valid     = vv;
        value           = v;
        avm_waitrequest = wr;
        prev_write      = avm_write;
        @(posedge clk);
        @(negedge clk);
        compare_all();
        if (avm_write && !prev_write) rises++;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 24'h0, 1'b0);
    endtask

    initial begin
        reset           = 1'b1;
        value           = '0;
        value_valid     = 1'b0;
        avm_waitrequest = 1'b0;
        prev_write      = 1'b0;
        rises           = 0;

        // Reset state
        repeat (3) do_reset();
        chk("rst_addr",  avm_address,   32'h0);
        chk("rst_data",  avm_writedata, 32'h0);
        chk("rst_write", 32'(avm_write), 32'h0);

        // Basic pair, fixed expected words
`ifndef DE1_SOC_HEX_LZB_EN
        cyc(1'b0, 1'b1, 24'h123456, 1'b0);
        chk("t1_lo_addr", avm_address,   32'h0000_0020);
        chk("t1_lo_data", avm_writedata, 32'h3019_1202);
        cyc(1'b0, 1'b0, 24'h0, 1'b0);
        chk("t1_hi_addr", avm_address,   32'h0000_0030);
        chk("t1_hi_data", avm_writedata, 32'h0000_7924);
        cyc(1'b0, 1'b0, 24'h0, 1'b0);
        chk("t1_done_write", 32'(avm_write), 32'h0);
        chk("t1_done_busy",  32'(busy),      32'h0);
`else
        cyc(1'b0, 1'b1, 24'h000042, 1'b0);
        chk("lzb42_lo", avm_writedata, 32'h7F7F_1924);
        cyc(1'b0, 1'b0, 24'h0, 1'b0);
        chk("lzb42_hi", avm_writedata, 32'h0000_7F7F);
        cyc(1'b0, 1'b0, 24'h0, 1'b0);
        cyc(1'b0, 1'b1, 24'h000000, 1'b0);
        chk("lzb0_lo", avm_writedata, 32'h7F7F_7F40);
        cyc(1'b0, 1'b0, 24'h0, 1'b0);
        chk("lzb0_hi", avm_writedata, 32'h0000_7F7F);
        cyc(1'b0, 1'b0, 24'h0, 1'b0);
`endif

        // LO held by waitrequest for 3 cycles
        do_reset();
        cyc(1'b0, 1'b1, 24'h123456, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 24'h0, 1'b1);
            chk("stall_addr",  avm_address,    32'h0000_0020);
            chk("stall_write", 32'(avm_write), 32'h1);
        end
        cyc(1'b0, 1'b0, 24'h0, 1'b0);
        chk("stall_hi_addr", avm_address, 32'h0000_0030);
        cyc(1'b0, 1'b0, 24'h0, 1'b0);

        // Update during a pair -> exactly one extra pair afterwards
        do_reset();
        rises = 0;
        cyc(1'b0, 1'b1, 24'h123456, 1'b0);
        cyc(1'b0, 1'b1, 24'hABCDEF, 1'b0);
        cyc(1'b0, 1'b0, 24'h0, 1'b0);
        cyc(1'b0, 1'b0, 24'h0, 1'b0);
        chk("inflight_lo", avm_writedata, 32'h4621_060E);
        cyc(1'b0, 1'b0, 24'h0, 1'b0);
        chk("inflight_hi", avm_writedata, 32'h0000_0803);
        cyc(1'b0, 1'b0, 24'h0, 1'b0);
        cyc(1'b0, 1'b0, 24'h0, 1'b0);
        chk("inflight_pairs", 32'(rises), 32'd2);

        // Reset while the HI word is on the bus
        do_reset();
        cyc(1'b0, 1'b1, 24'h654321, 1'b0);
        cyc(1'b0, 1'b0, 24'h0, 1'b0);
        do_reset();
        chk("rst_hi_write", 32'(avm_write), 32'h0);
        chk("rst_hi_busy",  32'(busy),      32'h0);
        rises = 0;
        repeat (3) cyc(1'b0, 1'b0, 24'h0, 1'b0);
        chk("rst_hi_no_more", 32'(rises), 32'd0);

        // Refresh only: one pair per R cycles
        do_reset();
        rises = 0;
        repeat (30) cyc(1'b0, 1'b0, 24'h0, 1'b0);
        chk("refresh_pairs", 32'(rises), 32'd3);

        // Tick while busy is dropped
        do_reset();
        rises = 0;
        repeat (6) cyc(1'b0, 1'b0, 24'h0, 1'b0);
        cyc(1'b0, 1'b1, 24'h00BEEF, 1'b0);
        repeat (8) cyc(1'b0, 1'b0, 24'h0, 1'b0);
        chk("tick_dropped_pairs", 32'(rises), 32'd1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 149) == 0),
                ($urandom_range(0, 4) == 0),
                24'($urandom()),
                ($urandom_range(0, 9) < 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
